fc_mac_acc: RTL

Streaming multiply-accumulate stage for the fully connected layer. It sits directly upstream of the FC ReLU stage and produces one 32-bit signed pre-activation sum per output neuron. For each neuron it consumes IN_LEN signed activation/weight pairs, adds a per-neuron bias, and presents the result with a one-cycle valid pulse. There is no backpressure, because the downstream stage always accepts.

---
 rtl/fc_mac_acc.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/fc_mac_acc.sv
// Purpose : streaming MAC for the FC layer -- bias + sum of IN_LEN signed products per neuron.
// Latency : valid_out rises 2 clocks after the edge that samples a neuron's last pair.
// Backpr. : none; downstream always accepts, one pair per clock sustained.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   valid_in              qualifies data_in / weight_in / bias_in
//   data_in, weight_in    signed DW-bit activation and weight
//   bias_in               signed 32-bit bias, taken on the first pair of a neuron
//   data_out              signed 32-bit neuron sum, held until the next result
//   valid_out             one-cycle result strobe
//   neuron_idx            index of the neuron on data_out
//   layer_done            pulses with valid_out of neuron NUM_OUT-1
//   busy                  high while a layer pass is in progress
//
// Build option: define FC_MAC_ACC_SAT_EN to widen the accumulator and clamp the
// result to the 32-bit signed range instead of wrapping modulo 2^32.
module fc_mac_acc #(
  parameter int IN_LEN  = 48,
  parameter int NUM_OUT = 10,
  parameter int DW      = 8,
  localparam int IW     = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1,
  localparam int CW     = $clog2(IN_LEN)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 valid_in,
  input  logic signed [DW-1:0] data_in,
  input  logic signed [DW-1:0] weight_in,
  input  logic signed [31:0]   bias_in,
  output logic signed [31:0]   data_out,
  output logic                 valid_out,
  output logic [IW-1:0]        neuron_idx,
  output logic                 layer_done,
  output logic                 busy
);

`ifdef FC_MAC_ACC_SAT_EN
  // Headroom for IN_LEN products on top of a full-range bias, so no partial sum wraps.
  localparam int ACC_W = 32 + $clog2(IN_LEN) + 1;
`else
  localparam int ACC_W = 32;
`endif

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t state_q, state_d;

  logic [CW-1:0]            in_cnt;
  logic [IW-1:0]            out_cnt;
  logic signed [2*DW-1:0]   p;
  logic                     p_valid;
  logic                     p_first;
  logic                     p_last;
  logic signed [31:0]       bias_q;
  logic signed [ACC_W-1:0]  acc;
  logic                     r_valid;   // acc holds a finished neuron sum
  logic [31:0]              acc_res;
  logic                     last_neuron;

  logic signed [ACC_W-1:0]  p_ext;
  logic signed [ACC_W-1:0]  b_ext;

  assign p_ext       = ACC_W'(p);
  assign b_ext       = ACC_W'(bias_q);
  assign last_neuron = (out_cnt == IW'(NUM_OUT - 1));

  // Stage 1: product register plus first/last tags for the accumulator.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_cnt  <= '0;
      p       <= '0;
      p_valid <= 1'b0;
      p_first <= 1'b0;
      p_last  <= 1'b0;
      bias_q  <= '0;
    end else begin
      p_valid <= valid_in;
      if (valid_in) begin
        p       <= (2*DW)'(data_in) * (2*DW)'(weight_in);
        p_first <= (in_cnt == '0);
        p_last  <= (in_cnt == CW'(IN_LEN - 1));
        if (in_cnt == '0) begin
          bias_q <= bias_in;
        end
        in_cnt  <= (in_cnt == CW'(IN_LEN - 1)) ? '0 : in_cnt + CW'(1);
      end
    end
  end

  // Stage 2: accumulate; the first product of a neuron restarts from the bias.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc     <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= p_valid && p_last;
      if (p_valid) begin
        acc <= (p_first ? b_ext : acc) + p_ext;
      end
    end
  end

`ifdef FC_MAC_ACC_SAT_EN
  // In range only when every bit from 31 upward equals the sign.
  logic [ACC_W-32:0] acc_hi;
  assign acc_hi = acc[ACC_W-1:31];
  always_comb begin
    acc_res = acc[31:0];
    if (!((&acc_hi) || !(|acc_hi))) begin
      acc_res = acc[ACC_W-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end
  end
`else
  assign acc_res = acc[31:0];
`endif

  // Stage 3: result register; data_out / neuron_idx hold between results.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_out   <= '0;
      valid_out  <= 1'b0;
      neuron_idx <= '0;
      layer_done <= 1'b0;
      out_cnt    <= '0;
    end else begin
      valid_out  <= r_valid;
      layer_done <= r_valid && last_neuron;
      if (r_valid) begin
        data_out   <= acc_res;
        neuron_idx <= out_cnt;
        out_cnt    <= last_neuron ? '0 : out_cnt + IW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Leaving BUSY coincides with the edge that raises valid_out for the last neuron.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (valid_in) state_d = BUSY;
      BUSY: if (r_valid && last_neuron) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == BUSY);

endmodule
